bnn_fc_fold: RTL and testbench

Parametrised, time-folded binary fully-connected layer. Accepts one IN_WIDTH-bit binarised activation vector and evaluates NUM_NEURONS neurons sequentially: XNOR against streamed weight chunks, accumulated popcount, threshold compare. Produces the packed NUM_NEURONS-bit output vector. It is the successor of the fixed 784-input single-neuron datapath: it adds configurable width and neuron count, chunked weight fetch from an external synchronous memory, a start/ready handshake and abort.

---
 rtl/bnn_pkg.sv | 27 ++
 rtl/bnn_popcount.sv | 31 +++
 rtl/bnn_fc_fold.sv | 180 ++++++++++++++++++
 tb/tb_bnn_fc_fold.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared types and elaboration-time helpers for the folded binary FC layer.
package bnn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Ceiling log2, floored at 1 so degenerate sizes still yield a legal vector width.
    function automatic int clog2(input int value);
        int res;
        int rem;
        res = 0;
        rem = value - 1;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        return (res < 1) ? 1 : res;
    endfunction

    function automatic int num_beats(input int in_width, input int chunk_w);
        return in_width / chunk_w;
    endfunction

endpackage

// File: rtl/bnn_popcount.sv
// Registered popcount of a W-bit word; result appears one cycle after the input.
module bnn_popcount
    import bnn_pkg::*;
#(
    parameter int W    = 112,
    parameter int CW   = clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  bits,
    output logic [CW-1:0] count
);

    logic [CW-1:0] sum;

    always_comb begin
        sum = '0;
        for (int i = 0; i < W; i++) begin
            sum = sum + CW'(bits[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= sum;
        end
    end

endmodule

// File: rtl/bnn_fc_fold.sv
// Time-folded binary fully-connected layer: one weight chunk per cycle, result after N*NB+2 edges.
// Start accepted only in IDLE; abort returns to IDLE at once and leaves o_result untouched.
module bnn_fc_fold
    import bnn_pkg::*;
#(
    parameter int IN_WIDTH    = 784,
    parameter int CHUNK_W     = 112,
    parameter int NUM_NEURONS = 256,
    parameter int ACC_W       = clog2(IN_WIDTH + 1),
    parameter int WA_W        = clog2(NUM_NEURONS * num_beats(IN_WIDTH, CHUNK_W)),
    parameter int NA_W        = clog2(NUM_NEURONS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [IN_WIDTH-1:0]    i_data,
    input  logic                   i_abort,
    output logic                   o_w_en,
    output logic [WA_W-1:0]        o_w_addr,
    output logic [NA_W-1:0]        o_n_addr,
    input  logic [CHUNK_W-1:0]     i_weight,
    input  logic [ACC_W-1:0]       i_threshold,
    output logic [NUM_NEURONS-1:0] o_result,
    output logic                   o_valid,
    output logic                   o_busy
);

    localparam int NB     = num_beats(IN_WIDTH, CHUNK_W);
    localparam int BEAT_W = clog2(NB);
    localparam int POP_W  = clog2(CHUNK_W + 1);

    state_t              state_q, state_d;
    logic                drain_q;
    logic                accept;
    logic [BEAT_W-1:0]   beat_q;
    logic [NA_W-1:0]     neuron_q;
    logic [WA_W-1:0]     waddr_q;
    logic [IN_WIDTH-1:0] act_q;
    logic                last_beat, last_issue;

    assign last_beat  = (beat_q == BEAT_W'(NB - 1));
    assign last_issue = last_beat && (neuron_q == NA_W'(NUM_NEURONS - 1));

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    state_d = ST_RUN;
                    accept  = 1'b1;
                end
            end
            ST_RUN:   if (last_issue) state_d = ST_DRAIN;
            ST_DRAIN: if (drain_q)    state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (i_abort) begin
            state_d = ST_IDLE;
            accept  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            drain_q  <= 1'b0;
            beat_q   <= '0;
            neuron_q <= '0;
            waddr_q  <= '0;
            act_q    <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= (state_q == ST_DRAIN) && !drain_q && !i_abort;
            // Counters rest at zero outside RUN so the addresses idle at 0.
            if (state_q == ST_RUN && !i_abort && !last_issue) begin
                waddr_q <= waddr_q + 1'b1;
                if (last_beat) begin
                    beat_q   <= '0;
                    neuron_q <= neuron_q + 1'b1;
                end else begin
                    beat_q <= beat_q + 1'b1;
                end
            end else begin
                waddr_q  <= '0;
                beat_q   <= '0;
                neuron_q <= '0;
            end
            if (accept) act_q <= i_data;
        end
    end

    assign o_w_en   = (state_q == ST_RUN);
    assign o_w_addr = waddr_q;
    assign o_n_addr = neuron_q;
    assign o_busy   = (state_q != ST_IDLE);
    assign o_ready  = rst_n && (state_q == ST_IDLE);

    // Issue tags wait one cycle alongside the memory read.
    logic              r_vld, r_last;
    logic [BEAT_W-1:0] r_beat;
    logic [NA_W-1:0]   r_neuron;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld    <= 1'b0;
            r_last   <= 1'b0;
            r_beat   <= '0;
            r_neuron <= '0;
        end else begin
            r_vld    <= o_w_en && !i_abort;
            r_last   <= last_beat;
            r_beat   <= beat_q;
            r_neuron <= neuron_q;
        end
    end

    logic [CHUNK_W-1:0] act_slice, match;
    logic [POP_W-1:0]   pop;

    assign act_slice = act_q[r_beat*CHUNK_W +: CHUNK_W];
    assign match     = ~(i_weight ^ act_slice);

    bnn_popcount #(.W(CHUNK_W), .CW(POP_W)) u_popcount (
        .clk   (clk),
        .rst_n (rst_n),
        .bits  (match),
        .count (pop)
    );

    logic             x_vld, x_first, x_last;
    logic [NA_W-1:0]  x_neuron;
    logic [ACC_W-1:0] x_thr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_vld    <= 1'b0;
            x_first  <= 1'b0;
            x_last   <= 1'b0;
            x_neuron <= '0;
            x_thr    <= '0;
        end else begin
            x_vld    <= r_vld && !i_abort;
            x_first  <= (r_beat == '0);
            x_last   <= r_last;
            x_neuron <= r_neuron;
            if (r_vld && r_last) x_thr <= i_threshold;
        end
    end

    logic [ACC_W-1:0]       acc_q, sum;
    logic [NUM_NEURONS-1:0] work_q, work_d;
    logic                   done;

    assign sum  = x_first ? ACC_W'(pop) : acc_q + ACC_W'(pop);
    assign done = x_vld && x_last && (x_neuron == NA_W'(NUM_NEURONS - 1)) && !i_abort;

    always_comb begin
        work_d           = work_q;
        work_d[x_neuron] = (sum >= x_thr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            work_q   <= '0;
            o_result <= '0;
            o_valid  <= 1'b0;
        end else begin
            if (x_vld && !i_abort) begin
                acc_q <= sum;
                if (x_last) work_q <= work_d;
            end
            o_valid <= done;
            if (done) o_result <= work_d;
        end
    end

endmodule

// File: tb/tb_bnn_fc_fold.sv
// Bench for bnn_fc_fold at IN_WIDTH=16, CHUNK_W=8, NUM_NEURONS=4 with a 1-cycle weight memory model.
module tb_bnn_fc_fold;

    localparam int LAT = 10;

    logic        clk, rst_n;
    logic        i_valid, o_ready, i_abort;
    logic [15:0] i_data;
    logic        o_w_en;
    logic [2:0]  o_w_addr;
    logic [1:0]  o_n_addr;
    logic [7:0]  i_weight;
    logic [4:0]  i_threshold;
    logic [3:0]  o_result;
    logic        o_valid, o_busy;

    bnn_fc_fold #(.IN_WIDTH(16), .CHUNK_W(8), .NUM_NEURONS(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_data      (i_data),
        .i_abort     (i_abort),
        .o_w_en      (o_w_en),
        .o_w_addr    (o_w_addr),
        .o_n_addr    (o_n_addr),
        .i_weight    (i_weight),
        .i_threshold (i_threshold),
        .o_result    (o_result),
        .o_valid     (o_valid),
        .o_busy      (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Weight/threshold memory with fixed one-cycle read latency.
    logic [7:0] wmem [8];
    logic [4:0] thr  [4];

    always @(posedge clk) begin
        if (o_w_en) begin
            i_weight    <= wmem[o_w_addr];
            i_threshold <= thr[o_n_addr];
        end
    end

    function automatic logic [3:0] model(input logic [15:0] d);
        logic [3:0] r;
        int cnt;
        r = '0;
        for (int n = 0; n < 4; n++) begin
            cnt = 0;
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < 8; i++)
                    if (d[b*8+i] == wmem[n*2+b][i]) cnt++;
            r[n] = (cnt >= int'(thr[n]));
        end
        return r;
    endfunction

    // Scoreboard: expected results and acceptance edges, popped on o_valid.
    logic [3:0] exp_q [$];
    int         st_q  [$];
    logic [2:0] addr_log [$];
    logic [3:0] held = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            held = '0;
        end else begin
            if (o_w_en) begin
                addr_log.push_back(o_w_addr);
                chk("n_addr", 32'(o_n_addr), 32'(o_w_addr >> 1));
            end
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_o_valid", 32'(o_valid), 32'd0);
                end else begin
                    chk("result", 32'(o_result), 32'(exp_q.pop_front()));
                    chk("latency", 32'(cyc - st_q.pop_front()), 32'(LAT));
                end
                held = o_result;
            end else begin
                chk("result_stable", 32'(o_result), 32'(held));
            end
        end
    end

    task automatic do_start(input logic [15:0] d, input logic [3:0] e);
        int n;
        @(negedge clk);
        i_valid = 1'b1;
        i_data  = d;
        n = 0;
        while (!o_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!o_ready) chk("start_timeout", 32'(o_ready), 32'd1);
        @(negedge clk);
        exp_q.push_back(e);
        st_q.push_back(cyc);
        i_valid = 1'b0;
        i_data  = ~d;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("done_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            st_q.delete();
        end
    endtask

    task automatic load_mem(input logic [7:0] wch, input logic [19:0] t);
        for (int i = 0; i < 8; i++) wmem[i] = wch;
        for (int n = 0; n < 4; n++) thr[n] = t[n*5 +: 5];
    endtask

    task automatic load_rand();
        for (int i = 0; i < 8; i++) wmem[i] = 8'($urandom);
        for (int n = 0; n < 4; n++) thr[n] = 5'($urandom_range(0, 17));
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_o_result"}, 32'(o_result), 32'd0);
        chk({tag, "_o_valid"},  32'(o_valid),  32'd0);
        chk({tag, "_o_w_en"},   32'(o_w_en),   32'd0);
        chk({tag, "_o_w_addr"}, 32'(o_w_addr), 32'd0);
        chk({tag, "_o_n_addr"}, 32'(o_n_addr), 32'd0);
        chk({tag, "_o_busy"},   32'(o_busy),   32'd0);
        chk({tag, "_o_ready"},  32'(o_ready),  32'd0);
    endtask

    typedef struct {
        logic [15:0] data;
        logic [7:0]  wch;
        logic [19:0] thr;   // {t3,t2,t1,t0}
        logic [3:0]  exp;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [15:0] d1, d2;
        vecs[0] = '{data: 16'hFFFF, wch: 8'hFF, thr: {5'd8,  5'd0,  5'd17, 5'd16}, exp: 4'b1101};
        vecs[1] = '{data: 16'h00FF, wch: 8'hFF, thr: {5'd8,  5'd8,  5'd8,  5'd8},  exp: 4'b1111};
        vecs[2] = '{data: 16'h00FF, wch: 8'hFF, thr: {5'd9,  5'd9,  5'd9,  5'd9},  exp: 4'b0000};
        vecs[3] = '{data: 16'h0000, wch: 8'h00, thr: {5'd17, 5'd16, 5'd0,  5'd31}, exp: 4'b0110};
        vecs[4] = '{data: 16'hA5A5, wch: 8'h5A, thr: {5'd1,  5'd0,  5'd1,  5'd0},  exp: 4'b0101};

        rst_n = 1'b0; i_valid = 1'b0; i_abort = 1'b0; i_data = '0;
        load_mem(8'h00, '0);
        #23;
        chk_zero_outputs("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_o_ready", 32'(o_ready), 32'd1);
        chk("idle_o_w_en",  32'(o_w_en),  32'd0);
        chk("idle_o_busy",  32'(o_busy),  32'd0);
        chk("idle_result",  32'(o_result), 32'd0);
        repeat (5) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            load_mem(vecs[v].wch, vecs[v].thr);
            addr_log.delete();
            do_start(vecs[v].data, vecs[v].exp);
            wait_done();
            if (v == 0) begin
                chk("addr_count", 32'(addr_log.size()), 32'd8);
                for (int k = 0; k < 8 && k < addr_log.size(); k++)
                    chk("w_addr_seq", 32'(addr_log[k]), 32'(k));
            end
            repeat (2) @(negedge clk);
        end

        // Random vectors against the reference model.
        for (int r = 0; r < 4; r++) begin
            load_rand();
            d1 = 16'($urandom);
            do_start(d1, model(d1));
            wait_done();
        end

        // Back-to-back: second request held pending through the first run.
        load_rand();
        d1 = 16'($urandom);
        d2 = ~d1 ^ 16'h3C5A;
        do_start(d1, model(d1));
        do_start(d2, model(d2));
        wait_done();
        repeat (3) @(negedge clk);

        // Abort on the 5th issue cycle.
        load_rand();
        d1 = 16'($urandom);
        do_start(d1, model(d1));
        repeat (4) @(negedge clk);
        chk("abort_issue_addr", 32'(o_w_addr), 32'd4);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        exp_q.delete();
        st_q.delete();
        chk("abort_busy",  32'(o_busy),  32'd0);
        chk("abort_w_en",  32'(o_w_en),  32'd0);
        chk("abort_ready", 32'(o_ready), 32'd1);
        repeat (15) @(negedge clk);
        i_valid = 1'b1;
        i_abort = 1'b1;
        @(negedge clk);
        chk("abort_blocks_start", 32'(o_busy), 32'd0);
        i_valid = 1'b0;
        i_abort = 1'b0;
        d2 = 16'($urandom);
        do_start(d2, model(d2));
        wait_done();

        // Asynchronous reset in the middle of RUN.
        load_rand();
        d1 = 16'($urandom);
        do_start(d1, model(d1));
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_zero_outputs("mid_reset");
        exp_q.delete();
        st_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", 32'(o_ready), 32'd1);
        chk("post_reset_busy",  32'(o_busy),  32'd0);
        load_mem(vecs[0].wch, vecs[0].thr);
        do_start(vecs[0].data, vecs[0].exp);
        wait_done();
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
